// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: opcodes,
// state encodings, ALUop / mux select codes and the control-word bundle.
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUop codes shared with ALUControl
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctl_t;

endpackage

// File: rtl/mips_multicycle_control_decode.sv
// Combinational Moore decode of the control state into datapath controls;
// only the FETCH-state IR/PC loads additionally depend on mem_ready.
module mips_multicycle_control_decode
  import mips_multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctl_t       ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMMSH;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_RTYPEEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALUOP_FUNC;
      end
      S_RTYPEWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_B;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      S_JEX: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register and
// next-state logic; output decode lives in mips_multicycle_control_decode.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state_q, state_d;
  ctl_t   ctl;
  logic   illegal;

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:   if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (MemReady) state_d = S_MEMWB;
      S_MEMWR:   if (MemReady) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mips_multicycle_control_decode u_decode (
    .state     (state_q),
    .mem_ready (MemReady),
    .ctl       (ctl)
  );

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign PCSource    = ctl.pc_source;
  assign ALUop       = ctl.alu_op;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign RegWrite    = ctl.reg_write;
  assign RegDst      = ctl.reg_dst;
  assign Illegal     = illegal;
  assign State       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS main control FSM; every output is
// packed into one word and compared against hand-written per-state values.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUop, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, Illegal;
  logic [3:0] State;

  int total = 0;
  int bad = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUop(ALUop),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg}_PCSource_ALUop_ALUSrcA_ALUSrcB_{RegWrite,RegDst,Illegal}_State
  logic [20:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal, State};

  localparam logic [20:0] E_F0   = 21'b0001000_00_00_0_01_000_0000;
  localparam logic [20:0] E_F1   = 21'b1001010_00_00_0_01_000_0000;
  localparam logic [20:0] E_DEC  = 21'b0000000_00_00_0_11_000_0001;
  localparam logic [20:0] E_DILL = 21'b0000000_00_00_0_11_001_0001;
  localparam logic [20:0] E_MADR = 21'b0000000_00_00_1_10_000_0010;
  localparam logic [20:0] E_MRD  = 21'b0011000_00_00_0_00_000_0011;
  localparam logic [20:0] E_MWB  = 21'b0000001_00_00_0_00_100_0100;
  localparam logic [20:0] E_MWR  = 21'b0010100_00_00_0_00_000_0101;
  localparam logic [20:0] E_REX  = 21'b0000000_00_10_1_00_000_0110;
  localparam logic [20:0] E_RWB  = 21'b0000000_00_00_0_00_110_0111;
  localparam logic [20:0] E_BEQ  = 21'b0100000_01_01_1_00_000_1000;
  localparam logic [20:0] E_JEX  = 21'b1000000_10_00_0_00_000_1001;
  localparam logic [20:0] E_AEX  = 21'b0000000_00_00_1_10_000_1010;
  localparam logic [20:0] E_AWB  = 21'b0000000_00_00_0_00_100_1011;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BADOP = 6'b111111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Opcode = R;
    MemReady = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if (obs !== E_F0) begin
      $display("FAIL reset_state got=%b want=%b", obs, E_F0);
      bad++;
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [20:0] ex [5];
    logic        mr [5];
    ex = '{E_F1, E_DEC, E_REX, E_RWB, E_F0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    Opcode = R;
    for (int i = 0; i < 5; i++) begin
      MemReady = mr[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        $display("FAIL rtype step%0d got=%b want=%b", i, obs, ex[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_lw_sw();
    logic [20:0] ex [10];
    logic [5:0]  op [10];
    logic        mr [10];
    ex = '{E_F1, E_DEC, E_MADR, E_MRD, E_MWB, E_F1, E_DEC, E_MADR, E_MWR, E_F0};
    op = '{LW, LW, LW, LW, LW, SW, SW, SW, SW, SW};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      Opcode = op[i];
      MemReady = mr[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        $display("FAIL lw_sw step%0d got=%b want=%b", i, obs, ex[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_beq_j_addi();
    logic [20:0] ex [11];
    logic [5:0]  op [11];
    ex = '{E_F1, E_DEC, E_BEQ, E_F1, E_DEC, E_JEX, E_F1, E_DEC, E_AEX, E_AWB, E_F0};
    op = '{BEQ, BEQ, BEQ, J, J, J, ADDI, ADDI, ADDI, ADDI, ADDI};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      Opcode = op[i];
      MemReady = (i != 10);
      #1;
      total++;
      if (obs !== ex[i]) begin
        $display("FAIL beq_j_addi step%0d got=%b want=%b", i, obs, ex[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_fetch_stall();
    logic [20:0] ex [6];
    logic        mr [6];
    ex = '{E_F0, E_F0, E_F0, E_F1, E_DEC, E_REX};
    mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    Opcode = R;
    for (int i = 0; i < 6; i++) begin
      MemReady = mr[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        $display("FAIL fetch_stall step%0d got=%b want=%b", i, obs, ex[i]);
        bad++;
      end
      tick();
    end
  endtask

  // Opcode is scrambled while in MEMRD to confirm it is ignored there.
  task automatic test_memrd_stall();
    logic [20:0] ex [8];
    logic [5:0]  op [8];
    logic        mr [8];
    ex = '{E_F1, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MWB, E_F0};
    op = '{LW, LW, LW, BADOP, R, SW, LW, LW};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      Opcode = op[i];
      MemReady = mr[i];
      #1;
      total++;
      if (obs !== ex[i]) begin
        $display("FAIL memrd_stall step%0d got=%b want=%b", i, obs, ex[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [20:0] ex [4];
    ex = '{E_F1, E_DILL, E_F0, E_F0};
    do_reset();
    Opcode = BADOP;
    for (int i = 0; i < 4; i++) begin
      MemReady = (i == 0);
      #1;
      total++;
      if (obs !== ex[i]) begin
        $display("FAIL illegal step%0d got=%b want=%b", i, obs, ex[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_reset_in_memwr();
    do_reset();
    Opcode = SW;
    MemReady = 1'b1;
    tick();
    tick();
    MemReady = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (obs !== E_MWR) begin
      $display("FAIL reset_memwr_pre got=%b want=%b", obs, E_MWR);
      bad++;
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (obs !== E_F0) begin
      $display("FAIL reset_memwr_post got=%b want=%b", obs, E_F0);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq_j_addi();
    test_fetch_stall();
    test_memrd_stall();
    test_illegal();
    test_reset_in_memwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
